stage2_inv_pipe: RTL and testbench
==================================

Name: stage2_inv_pipe

Overview:
- Decrypt-side inverse of the encrypt stage-2 bit-permutation stage.
- Takes four 8-bit bytes plus the two key bits (k7, k6) that selected the forward permutation, and applies the inverse permutation to each byte.
- Unlike the stalling-free encrypt stage, it has a valid/ready handshake, a one-entry skid buffer so back-pressure never drops a beat, and a beat counter for the decrypt-path controller.
- Sits between decrypt stage 3 output and decrypt stage 1 input.

Parameters:
- COUNT_W, 16, width of the accepted-beat counter; wraps modulo 2^COUNT_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Enable  in  1  stage enable; when low the stage freezes (no accept, no output change).
- in_valid  in  1  input beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- a0,a1,a2,a3  in  8 each  ciphertext bytes of the beat.
- k7,k6  in  1 each  key bits for this beat; mode = {k7,k6}, sampled with the data.
- out_valid  out  1  w0..w3 hold a valid beat.
- out_ready  in  1  downstream accepts the beat this cycle.
- w0,w1,w2,w3  out  8 each  inverse-permuted bytes.
- out_mode  out  2  {k7,k6} of the beat currently on w0..w3.
- beat_count  out  COUNT_W  number of beats accepted since reset.

Behaviour:
- Reset is asynchronous, active-high, and applies while asserted:
  - w0..w3 = 0, out_mode = 0, out_valid = 0, beat_count = 0.
  - Skid buffer empty.
  - in_ready = 0 while reset is high.
- Outputs are never driven to Z; registers hold their value whenever they are not loaded.
- Inverse permutation per byte (x = input byte, y = output byte), identical for all four bytes. All four mappings are involutions, so each equals its forward counterpart.
  - mode 00, pair swap: y = {x6,x7,x4,x5,x2,x3,x0,x1}.
  - mode 10, nibble swap: y = {x3,x2,x1,x0,x7,x6,x5,x4}.
  - mode 01, bit reverse: y = {x0,x1,x2,x3,x4,x5,x6,x7}.
  - mode 11, swap 7<->1 and 5<->3: y = {x1,x6,x3,x4,x5,x2,x7,x0}.
- The permutation is applied combinationally before the register. The mode stored with each beat is the mode sampled at acceptance.
- in_ready = Enable & !skid_full (combinational; does not depend on in_valid).
- Accept condition: in_valid & in_ready at a rising edge.
- States: EMPTY (out_valid=0), ONE (out_valid=1, skid empty), FULL (out_valid=1, skid full).
  - EMPTY: accept -> ONE. The beat loads into the output register, so latency is 1 cycle.
  - ONE, accept & out_ready: stays ONE; the new beat replaces the output register.
  - ONE, accept & !out_ready: -> FULL; the new beat goes to the skid buffer.
  - ONE, no accept & out_ready: -> EMPTY.
  - FULL, out_ready: -> ONE; the skid contents move to the output register. No accept is possible because in_ready = 0.
- Enable = 0 freezes all state:
  - No transfer completes, even if out_ready = 1.
  - out_valid, w*, out_mode and beat_count hold.
  - in_ready = 0.
- beat_count increments by 1 on every accept and wraps from 2^COUNT_W-1 to 0.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- Asserting reset mid-operation discards both the output register and the skid buffer contents immediately.

Test Plan:
- After reset, Enable=1, out_ready=1, send a0..a3=B4,B4,B4,B4 in modes 00, 10, 01, 11 on consecutive cycles:
  - w0..w3 = 78, 4B, 2D, 1E respectively, one cycle after each accept.
  - out_valid is high continuously.
  - beat_count = 4.
- Round trip: feed each mode's output back in with the same mode (e.g. 1E, mode 11) -> B4 is restored for all four modes.
- Back-pressure: hold out_ready=0 and send two beats (B4 mode 00, then B4 mode 01):
  - State reaches FULL; in_ready = 0; w = 78.
  - Raise out_ready -> next cycle w = 2D; in_ready = 1.
  - The third-cycle out_ready pulse drains to EMPTY.
- Enable low with in_valid=1, out_ready=1 for 3 cycles -> in_ready=0, outputs and beat_count unchanged, no Z on w*.
- Assert reset while FULL -> out_valid=0, w*=0, beat_count=0 asynchronously. The first beat after release appears with latency 1.
- COUNT_W=4: accept 17 beats -> beat_count = 1 (wrap verified).

Source files
------------

// File: rtl/stage2_inv_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : stage2_inv_pipe
//  Purpose  : Decrypt-side inverse of the stage-2 bit permutation. Each beat
//             of four bytes is inverse-permuted under the 2-bit mode {k7,k6},
//             registered behind a valid/ready handshake with a one-entry
//             skid buffer, and counted in a wrapping accepted-beat counter.
//  Revision : 1.0  initial release
// ============================================================================
module stage2_inv_pipe #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         a0,
    input  logic [7:0]         a1,
    input  logic [7:0]         a2,
    input  logic [7:0]         a3,
    input  logic               k7,
    input  logic               k6,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         w0,
    output logic [7:0]         w1,
    output logic [7:0]         w2,
    output logic [7:0]         w3,
    output logic [1:0]         out_mode,
    output logic [COUNT_W-1:0] beat_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // All four mappings are involutions, so inverse == forward.
    function automatic logic [7:0] inv_perm(input logic [7:0] x, input logic [1:0] m);
        logic [7:0] y;
        case (m)
            2'b00:   y = {x[6], x[7], x[4], x[5], x[2], x[3], x[0], x[1]};
            2'b10:   y = {x[3:0], x[7:4]};
            2'b01:   y = {x[0], x[1], x[2], x[3], x[4], x[5], x[6], x[7]};
            default: y = {x[1], x[6], x[3], x[4], x[5], x[2], x[7], x[0]};
        endcase
        return y;
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [1:0]         out_mode_q, out_mode_d;
    logic [31:0]        skid_data_q, skid_data_d;
    logic [1:0]         skid_mode_q, skid_mode_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [1:0]  w_mode;
    logic [31:0] w_perm;
    logic        w_accept;
    logic        w_drain;

    assign w_mode = {k7, k6};
    assign w_perm = {inv_perm(a0, w_mode), inv_perm(a1, w_mode),
                     inv_perm(a2, w_mode), inv_perm(a3, w_mode)};

    // Gated by reset so the upstream never sees ready while we are held in reset.
    assign in_ready  = Enable & ~reset & (state_q != ST_FULL);
    assign w_accept  = in_valid & in_ready;
    // With Enable low nothing leaves the stage, even if downstream is ready.
    assign w_drain   = Enable & out_valid & out_ready;

    assign out_valid  = (state_q != ST_EMPTY);
    assign w0         = out_data_q[31:24];
    assign w1         = out_data_q[23:16];
    assign w2         = out_data_q[15:8];
    assign w3         = out_data_q[7:0];
    assign out_mode   = out_mode_q;
    assign beat_count = count_q;

    // Next-state: handshake FSM steering new beats to output or skid register.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        skid_data_d = skid_data_q;
        skid_mode_d = skid_mode_q;
        count_d     = count_q + (w_accept ? COUNT_W'(1) : COUNT_W'(0));
        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    out_data_d = w_perm;
                    out_mode_d = w_mode;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    out_data_d = w_perm;
                    out_mode_d = w_mode;
                end else if (w_accept) begin
                    skid_data_d = w_perm;
                    skid_mode_d = w_mode;
                    state_d     = ST_FULL;
                end else if (w_drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    out_data_d = skid_data_q;
                    out_mode_d = skid_mode_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State registers; reset discards both the output and the skid entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            out_mode_q  <= '0;
            skid_data_q <= '0;
            skid_mode_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
            skid_data_q <= skid_data_d;
            skid_mode_q <= skid_mode_d;
            count_q     <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage2_inv_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage2_inv_pipe
//  Purpose  : Directed self-checking bench for stage2_inv_pipe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stage2_inv_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        Enable;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a0, a1, a2, a3;
    logic        k7, k6;

    logic        in_ready, out_valid;
    logic [7:0]  w0, w1, w2, w3;
    logic [1:0]  out_mode;
    logic [15:0] beat_count;

    logic        s_in_ready, s_out_valid;
    logic [7:0]  s_w0, s_w1, s_w2, s_w3;
    logic [1:0]  s_out_mode;
    logic [3:0]  s_beat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage2_inv_pipe #(.COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .Enable(Enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .k7(k7), .k6(k6),
        .out_valid(out_valid), .out_ready(out_ready),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3),
        .out_mode(out_mode), .beat_count(beat_count)
    );

    stage2_inv_pipe #(.COUNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .Enable(Enable),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .k7(k7), .k6(k6),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .w0(s_w0), .w1(s_w1), .w2(s_w2), .w3(s_w3),
        .out_mode(s_out_mode), .beat_count(s_beat_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [7:0] exp);
        chk(tag, {w0, w1, w2, w3}, {4{exp}});
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m);
        in_valid = v;
        a0 = d; a1 = d; a2 = d; a3 = d;
        {k7, k6} = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; Enable = 1'b1; out_ready = 1'b1;
        drive(1'b0, 8'h00, 2'b00);
        #1;
        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk_w("rst_w", 8'h00);
        chk("rst_mode", {30'd0, out_mode}, 32'd0);
        chk("rst_count", {16'd0, beat_count}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Four modes on consecutive cycles, out_ready high
        drive(1'b1, 8'hB4, 2'b00); tick();
        chk_w("m00_w", 8'h78);
        chk("m00_valid", {31'd0, out_valid}, 32'd1);
        chk("m00_mode", {30'd0, out_mode}, 32'd0);
        drive(1'b1, 8'hB4, 2'b10); tick();
        chk_w("m10_w", 8'h4B);
        chk("m10_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b1, 8'hB4, 2'b01); tick();
        chk_w("m01_w", 8'h2D);
        chk("m01_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b1, 8'hB4, 2'b11); tick();
        chk_w("m11_w", 8'h1E);
        chk("m11_mode", {30'd0, out_mode}, 32'd3);
        chk("m11_count", {16'd0, beat_count}, 32'd4);

        // Round trip: each output fed back under its own mode restores B4
        drive(1'b1, 8'h78, 2'b00); tick(); chk_w("rt00_w", 8'hB4);
        drive(1'b1, 8'h4B, 2'b10); tick(); chk_w("rt10_w", 8'hB4);
        drive(1'b1, 8'h2D, 2'b01); tick(); chk_w("rt01_w", 8'hB4);
        drive(1'b1, 8'h1E, 2'b11); tick(); chk_w("rt11_w", 8'hB4);
        chk("rt_count", {16'd0, beat_count}, 32'd8);
        drive(1'b0, 8'h00, 2'b00); tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Back-pressure fills the skid buffer
        out_ready = 1'b0;
        drive(1'b1, 8'hB4, 2'b00); tick();
        chk_w("bp1_w", 8'h78);
        chk("bp1_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 8'hB4, 2'b01); tick();
        chk_w("bp2_w", 8'h78);
        chk("bp2_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp2_count", {16'd0, beat_count}, 32'd10);
        drive(1'b0, 8'h00, 2'b00);
        out_ready = 1'b1; tick();
        chk_w("bp3_w", 8'h2D);
        chk("bp3_mode", {30'd0, out_mode}, 32'd1);
        chk("bp3_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp3_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp4_valid", {31'd0, out_valid}, 32'd0);

        // Freeze with Enable low while a beat is held
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 2'b00); tick();
        chk_w("en_load_w", 8'h22);
        Enable = 1'b0; out_ready = 1'b1;
        drive(1'b1, 8'hB4, 2'b11);
        #1;
        chk("en_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_w("en_w", 8'h22);
            chk("en_valid", {31'd0, out_valid}, 32'd1);
            chk("en_count", {16'd0, beat_count}, 32'd11);
            chk("en_noz", {31'd0, $isunknown({w0, w1, w2, w3})}, 32'd0);
        end

        // Fill to FULL, then reset asynchronously mid-cycle
        Enable = 1'b1; out_ready = 1'b0;
        drive(1'b1, 8'hB4, 2'b10); tick();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_count", {16'd0, beat_count}, 32'd12);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk_w("arst_w", 8'h00);
        chk("arst_count", {16'd0, beat_count}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0; out_ready = 1'b1;
        drive(1'b1, 8'hB4, 2'b11);
        #1;
        chk("post_pre_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk_w("post_w", 8'h1E);
        chk("post_valid", {31'd0, out_valid}, 32'd1);
        chk("post_count", {16'd0, beat_count}, 32'd1);

        // Wrap of the 4-bit counter after 17 accepts
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 2'b01); tick();
        end
        chk_w("wrap_last_w", 8'hF0);
        chk("wrap_count16", {16'd0, beat_count}, 32'd17);
        chk("wrap_count4", {28'd0, s_beat_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
